wb_grf: RTL

- Write-back end of the MEM/WB interface: consumes the W-stage pipeline fields and commits results into the 32x32 general register file.
- Performs load extraction/extension, link-value and movz selection, and exception write suppression.
- Serves the two D-stage read ports with same-cycle write-through bypass.
- Keeps a retired-instruction counter for testbench/debug.

---
 rtl/wb_grf.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_grf.sv
// Write-back stage: load extraction, link/movz selection, exception suppression,
// the 32x32 register file with write-through read ports, and a retire counter.
module wb_grf #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_W,
    input  logic [31:0] data_dm_W,
    input  logic [31:0] data_alu_W,
    input  logic [4:0]  writereg_W,
    input  logic [31:0] pcout_W,
    input  logic        movz_W,
    input  logic [31:0] W_extpt,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] retire_cnt
);

    logic [31:0] regs [1:31];
    logic [31:0] retire_q;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_lw, is_lb, is_lbu, is_lh, is_lhu, is_jal, is_jalr, is_movz;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        retire;

    assign opcode  = instr_W[31:26];
    assign funct   = instr_W[5:0];
    assign is_lw   = (opcode == 6'b100011);
    assign is_lb   = (opcode == 6'b100000);
    assign is_lbu  = (opcode == 6'b100100);
    assign is_lh   = (opcode == 6'b100001);
    assign is_lhu  = (opcode == 6'b100101);
    assign is_jal  = (opcode == 6'b000011);
    assign is_jalr = (opcode == 6'b000000) && (funct == 6'b001001);
    assign is_movz = (opcode == 6'b000000) && (funct == 6'b001010);

    // Low address bits pick the lane; bit 0 is ignored for halves since misalignment traps upstream.
    always_comb begin
        load_byte = data_dm_W[7:0];
        case (data_alu_W[1:0])
            2'd0: load_byte = data_dm_W[7:0];
            2'd1: load_byte = data_dm_W[15:8];
            2'd2: load_byte = data_dm_W[23:16];
            2'd3: load_byte = data_dm_W[31:24];
            default: load_byte = data_dm_W[7:0];
        endcase
        load_half = data_alu_W[1] ? data_dm_W[31:16] : data_dm_W[15:0];
    end

    always_comb begin
        wb_data = data_alu_W;
        if (is_lw)
            wb_data = data_dm_W;
        else if (is_lb)
            wb_data = {{24{load_byte[7]}}, load_byte};
        else if (is_lbu)
            wb_data = {24'd0, load_byte};
        else if (is_lh)
            wb_data = {{16{load_half[15]}}, load_half};
        else if (is_lhu)
            wb_data = {16'd0, load_half};
        else if (is_jal || is_jalr)
            wb_data = pcout_W + LINK_OFFSET;
    end

    assign wb_we   = (writereg_W != 5'd0) && (W_extpt == 32'd0) && (instr_W != 32'd0)
                     && (!is_movz || movz_W);
    assign wb_addr = writereg_W;
    assign retire  = (instr_W != 32'd0) && (W_extpt == 32'd0) && (pcout_W != RESET_PC);

    // Read ports see the value being written this cycle so decode needs no extra forwarding.
    always_comb begin
        rd1 = 32'd0;
        rd2 = 32'd0;
        if (ra1 != 5'd0)
            rd1 = (wb_we && ra1 == wb_addr) ? wb_data : regs[ra1];
        if (ra2 != 5'd0)
            rd2 = (wb_we && ra2 == wb_addr) ? wb_data : regs[ra2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            if (wb_we)
                regs[wb_addr] <= wb_data;
            if (retire)
                retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;

endmodule
